// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the core run-control front end.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    CORE_RST = 2'd0,
    PAUSED   = 2'd1,
    RUN      = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam logic [7:0] HALT_OPCODE = 8'h70;

  localparam int DEF_DEBOUNCE_BITS = 16;
  localparam int DEF_TICK_BITS     = 11;
  localparam int DEF_RST_CYCLES    = 4;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop sync, stability counter,
// one-clock pulse on a debounced press (1 -> 0).
import cpu_ctrl_pkg::*;

module btn_debounce #(
  parameter int DEBOUNCE_BITS = DEF_DEBOUNCE_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic [1:0]               sync;
  logic [DEBOUNCE_BITS-1:0] cnt;
  logic                     level;
  logic                     level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= 2'b11;
      cnt     <= '0;
      level   <= 1'b1;
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], btn_n};
      level_d <= level;
      press   <= level_d & ~level;
      // count only while a change is pending; any agreement restarts it
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (&cnt) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/pause/step/reset control producing the core clock-enable,
// reset request, status bits and a strobe counter.
import cpu_ctrl_pkg::*;

module cpu_step_ctrl #(
  parameter int DEBOUNCE_BITS = DEF_DEBOUNCE_BITS,
  parameter int TICK_BITS     = DEF_TICK_BITS,
  parameter int RST_CYCLES    = DEF_RST_CYCLES
) (
  input  logic       CLK_12MHz,
  input  logic       RST,
  input  logic       btn_run_n,
  input  logic       btn_step_n,
  input  logic       btn_reset_n,
  input  logic       halt_in,
  output logic       cpu_en,
  output logic       cpu_rst,
  output logic       running,
  output logic       halted,
  output logic [7:0] step_count
);

  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

  logic run_press;
  logic step_press;
  logic rst_press;

  btn_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_run (
    .clk   (CLK_12MHz),
    .rst   (RST),
    .btn_n (btn_run_n),
    .press (run_press)
  );

  btn_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_step (
    .clk   (CLK_12MHz),
    .rst   (RST),
    .btn_n (btn_step_n),
    .press (step_press)
  );

  btn_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_reset (
    .clk   (CLK_12MHz),
    .rst   (RST),
    .btn_n (btn_reset_n),
    .press (rst_press)
  );

  state_t               state;
  state_t               nxt;
  logic [3:0]           rst_cnt;
  logic [3:0]           rst_cnt_nxt;
  logic [TICK_BITS-1:0] tick_cnt;
  logic [TICK_BITS-1:0] tick_nxt;
  logic                 en_nxt;

  // event priority: reset > halt > run > step
  always_comb begin
    nxt         = state;
    rst_cnt_nxt = rst_cnt;
    tick_nxt    = tick_cnt;
    en_nxt      = 1'b0;
    unique case (state)
      CORE_RST: begin
        if (rst_press) begin
          rst_cnt_nxt = '0;
        end else if (rst_cnt == RST_LAST) begin
          nxt         = PAUSED;
          rst_cnt_nxt = '0;
        end else begin
          rst_cnt_nxt = rst_cnt + 1'b1;
        end
      end
      PAUSED: begin
        if (rst_press) begin
          nxt         = CORE_RST;
          rst_cnt_nxt = '0;
        end else if (halt_in) begin
          nxt = HALTED;
        end else if (run_press) begin
          nxt      = RUN;
          tick_nxt = '0;
        end else if (step_press) begin
          en_nxt = 1'b1;
        end
      end
      RUN: begin
        tick_nxt = tick_cnt + 1'b1;
        if (rst_press) begin
          nxt         = CORE_RST;
          rst_cnt_nxt = '0;
        end else if (halt_in) begin
          nxt = HALTED;
        end else if (run_press) begin
          nxt = PAUSED;
        end else if (&tick_cnt) begin
          en_nxt = 1'b1;
        end
      end
      HALTED: begin
        if (rst_press) begin
          nxt         = CORE_RST;
          rst_cnt_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK_12MHz or posedge RST) begin
    if (RST) begin
      state      <= CORE_RST;
      rst_cnt    <= '0;
      tick_cnt   <= '0;
      step_count <= '0;
      cpu_en     <= 1'b0;
      cpu_rst    <= 1'b1;
      running    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state    <= nxt;
      rst_cnt  <= rst_cnt_nxt;
      tick_cnt <= tick_nxt;
      cpu_en   <= en_nxt;
      cpu_rst  <= (nxt == CORE_RST);
      running  <= (nxt == RUN);
      halted   <= (nxt == HALTED);
      if (nxt == CORE_RST) begin
        step_count <= '0;
      end else if (en_nxt) begin
        step_count <= step_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with short debounce/tick widths.
module tb_cpu_step_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_run_n = 1'b1;
  logic       btn_step_n = 1'b1;
  logic       btn_reset_n = 1'b1;
  logic       halt_in = 1'b0;
  logic       cpu_en;
  logic       cpu_rst;
  logic       running;
  logic       halted;
  logic [7:0] step_count;

  int tests = 0;
  int fails = 0;
  int en_cnt = 0;
  int bad = 0;
  int cyc = 0;
  int last_en = -1;
  int gap = 0;

  always #5 clk = ~clk;

  cpu_step_ctrl #(
    .DEBOUNCE_BITS (3),
    .TICK_BITS     (4),
    .RST_CYCLES    (4)
  ) dut (
    .CLK_12MHz   (clk),
    .RST         (rst),
    .btn_run_n   (btn_run_n),
    .btn_step_n  (btn_step_n),
    .btn_reset_n (btn_reset_n),
    .halt_in     (halt_in),
    .cpu_en      (cpu_en),
    .cpu_rst     (cpu_rst),
    .running     (running),
    .halted      (halted),
    .step_count  (step_count)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cpu_en) begin
      en_cnt++;
      if (last_en >= 0) gap = cyc - last_en;
      last_en = cyc;
      if (cpu_rst || halted) bad++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       btn_run_n = v;
      1:       btn_step_n = v;
      default: btn_reset_n = v;
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    @(posedge clk);
    #1;
    set_btn(b, 1'b0);
    tick(15);
    set_btn(b, 1'b1);
    tick(15);
  endtask

  initial begin
    int n, e0, first, r11, r12, rk, scb;

    // reset state and reset stretch
    tick(3);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_running", running, 0);
    check("rst_halted", halted, 0);
    check("rst_step_count", step_count, 0);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (cpu_rst) n++;
      tick(1);
    end
    check("rst_len", n, 4);
    e0 = en_cnt;
    tick(100);
    check("idle_no_en", en_cnt - e0, 0);
    check("idle_step_count", step_count, 0);
    check("idle_running", running, 0);
    check("idle_cpu_rst", cpu_rst, 0);

    // single step with bounce
    e0 = en_cnt;
    @(posedge clk);
    #1;
    btn_step_n = 1'b0;
    tick(30);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      btn_step_n = ~btn_step_n;
    end
    btn_step_n = 1'b0;
    tick(20);
    btn_step_n = 1'b1;
    tick(30);
    check("step_one_en", en_cnt - e0, 1);
    check("step_count_1", step_count, 1);

    // run mode pacing
    n = 0;
    first = 0;
    r11 = -1;
    r12 = -1;
    @(posedge clk);
    #1;
    btn_run_n = 1'b0;
    for (int k = 1; k <= 600 && n < 20; k++) begin
      tick(1);
      if (k == 11) r11 = int'(running);
      if (k == 12) r12 = int'(running);
      if (k == 15) btn_run_n = 1'b1;
      if (cpu_en) begin
        n++;
        if (first == 0) first = k;
      end
    end
    check("run_before_press", r11, 0);
    check("run_entered", r12, 1);
    check("run_first_en", first, 28);
    check("run_strobes", n, 20);
    check("run_step_count", step_count, 21);
    check("run_period", gap, 16);

    // second run press pauses
    press(0);
    e0 = en_cnt;
    tick(100);
    check("pause_no_en", en_cnt - e0, 0);
    check("pause_running", running, 0);

    // halt coincident with run press
    press(0);
    check("rerun_running", running, 1);
    @(posedge clk);
    #1;
    btn_run_n = 1'b0;
    tick(11);
    halt_in = 1'b1;
    tick(1);
    halt_in = 1'b0;
    check("halt_halted", halted, 1);
    check("halt_running", running, 0);
    tick(5);
    btn_run_n = 1'b1;
    tick(15);
    e0 = en_cnt;
    press(0);
    press(1);
    check("halt_no_en", en_cnt - e0, 0);
    check("halt_stays", halted, 1);

    // reset press leaves HALTED
    n = 0;
    rk = 0;
    scb = 0;
    @(posedge clk);
    #1;
    btn_reset_n = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (cpu_rst) begin
        n++;
        if (rk == 0) rk = k;
        if (step_count != 8'd0) scb++;
      end
    end
    check("crst_start", rk, 12);
    check("crst_len", n, 4);
    check("crst_step_zero", scb, 0);
    check("crst_halted", halted, 0);
    check("crst_running", running, 0);
    check("crst_step_count", step_count, 0);
    btn_reset_n = 1'b1;
    tick(15);

    // step counter wrap
    e0 = en_cnt;
    for (int i = 0; i < 255; i++) press(1);
    check("wrap_255", step_count, 255);
    press(1);
    check("wrap_0", step_count, 0);
    check("wrap_en_total", en_cnt - e0, 256);

    // async reset mid-run
    press(0);
    tick(50);
    check("arst_pre_running", running, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_cpu_rst", cpu_rst, 1);
    check("arst_cpu_en", cpu_en, 0);
    check("arst_running", running, 0);
    check("arst_halted", halted, 0);
    check("arst_step_count", step_count, 0);
    check("en_invariant", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
